// File: rtl/cfg_bus_arbiter_if.sv
// Configuration-bus arbiter port bundle: requester handshake, responses
// and the shared configuration bus towards the slaves.
interface cfg_bus_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 14,
    parameter int N_SLV  = 3
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic                    rsp_err;
    logic                    c_valid;
    logic [ADDR_W-1:0]       c_addr;
    logic [DATA_W-1:0]       c_data;
    logic [N_SLV-1:0]        c_ready;

    // Arbiter side: owns the bus and the request/response strobes.
    modport master (
        input  req_valid, req_addr, req_data, c_ready,
        output req_ready, rsp_valid, rsp_err, c_valid, c_addr, c_data
    );

    // Environment side: requesters and slaves.
    modport slave (
        output req_valid, req_addr, req_data, c_ready,
        input  req_ready, rsp_valid, rsp_err, c_valid, c_addr, c_data
    );
endinterface

// File: rtl/cfg_bus_arbiter.sv
// Round-robin arbiter and sole master of the shared configuration bus.
// One write in flight at a time; completes when every slave is ready,
// aborts after TIMEOUT drive cycles, then leaves one idle bus cycle.
module cfg_bus_arbiter #(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 14,
    parameter int N_SLV   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    cfg_bus_arbiter_if.master bus,
    output logic              busy,
    output logic [7:0]        err_cnt
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0]   grant_reg, grant_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic [ADDR_W-1:0]  c_addr_reg, c_addr_next;
    logic [DATA_W-1:0]  c_data_reg, c_data_next;
    logic               c_valid_reg, c_valid_next;
    logic [N_REQ-1:0]   req_ready_reg, req_ready_next;
    logic [N_REQ-1:0]   rsp_valid_reg, rsp_valid_next;
    logic               rsp_err_reg, rsp_err_next;
    logic               busy_reg, busy_next;
    logic [7:0]         err_cnt_reg, err_cnt_next;

    logic [ADDR_W-1:0]  addr_slice [N_REQ];
    logic [DATA_W-1:0]  data_slice [N_REQ];
    logic               found;
    logic [PTR_W-1:0]   pick;

    // Unpack the flattened request buses into per-requester slices.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign addr_slice[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign data_slice[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end

    // Round-robin pick: first requesting index starting at rr_ptr, wrapping.
    always_comb begin : pick_rr
        logic [PTR_W:0] idx;
        idx   = '0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(N_REQ)) begin
                idx = idx - (PTR_W+1)'(N_REQ);
            end
            if (!found && bus.req_valid[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[PTR_W-1:0];
            end
        end
    end

    // Next-state and registered-output logic; strobes default to zero.
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_next     = grant_reg;
        timer_next     = timer_reg;
        c_addr_next    = c_addr_reg;
        c_data_next    = c_data_reg;
        c_valid_next   = c_valid_reg;
        req_ready_next = '0;
        rsp_valid_next = '0;
        rsp_err_next   = 1'b0;
        err_cnt_next   = err_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    c_addr_next    = addr_slice[pick];
                    c_data_next    = data_slice[pick];
                    c_valid_next   = 1'b1;
                    req_ready_next = N_REQ'(1) << pick;
                    grant_next     = pick;
                    rr_ptr_next    = (pick == PTR_W'(N_REQ - 1)) ? '0 : pick + PTR_W'(1);
                    timer_next     = '0;
                    state_next     = DRIVE;
                end
            end
            DRIVE: begin
                // All-ready is tested first so it wins over a coincident timeout.
                if (&bus.c_ready) begin
                    c_valid_next   = 1'b0;
                    rsp_valid_next = N_REQ'(1) << grant_reg;
                    state_next     = GAP;
                end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
                    c_valid_next   = 1'b0;
                    rsp_valid_next = N_REQ'(1) << grant_reg;
                    rsp_err_next   = 1'b1;
                    if (err_cnt_reg != 8'hFF) begin
                        err_cnt_next = err_cnt_reg + 8'd1;
                    end
                    state_next     = GAP;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            GAP: begin
                c_valid_next = 1'b0;
                state_next   = IDLE;
            end
            default: begin
                c_valid_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // State and output registers; reset clears the bus immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            grant_reg     <= '0;
            timer_reg     <= '0;
            c_addr_reg    <= '0;
            c_data_reg    <= '0;
            c_valid_reg   <= 1'b0;
            req_ready_reg <= '0;
            rsp_valid_reg <= '0;
            rsp_err_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_reg     <= grant_next;
            timer_reg     <= timer_next;
            c_addr_reg    <= c_addr_next;
            c_data_reg    <= c_data_next;
            c_valid_reg   <= c_valid_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            busy_reg      <= busy_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    assign bus.c_valid   = c_valid_reg;
    assign bus.c_addr    = c_addr_reg;
    assign bus.c_data    = c_data_reg;
    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign busy          = busy_reg;
    assign err_cnt       = err_cnt_reg;
endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Self-checking bench: transaction-level model compared every cycle against
// two arbiters (TIMEOUT 255 and 8), plus directed literal expectations.
module tb_cfg_bus_arbiter;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy0, busy1;
    logic [7:0] err0, err1;
    int         errors = 0;
    int         checks = 0;

    cfg_bus_arbiter_if bi0 ();
    cfg_bus_arbiter_if bi1 ();

    cfg_bus_arbiter #(.TIMEOUT(255)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bi0), .busy(busy0), .err_cnt(err0)
    );
    cfg_bus_arbiter #(.TIMEOUT(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bi1), .busy(busy1), .err_cnt(err1)
    );

    always #5 clk = ~clk;

    // Model: who owns the bus, how long it has driven, whether a gap follows.
    int          m_owner [2];
    int          m_age   [2];
    int          m_rr    [2];
    bit          m_gap   [2];
    int          m_to    [2] = '{255, 8};
    logic [1:0]  e_rr    [2];
    logic [1:0]  e_rv    [2];
    logic        e_err   [2];
    logic        e_cv    [2];
    logic        e_busy  [2];
    logic [3:0]  e_addr  [2];
    logic [13:0] e_data  [2];
    int          e_cnt   [2];

    task automatic model_reset(input int k);
        m_owner[k] = -1; m_age[k] = 0; m_rr[k] = 0; m_gap[k] = 0;
        e_rr[k] = 0; e_rv[k] = 0; e_err[k] = 0; e_cv[k] = 0; e_busy[k] = 0;
        e_addr[k] = 0; e_data[k] = 0; e_cnt[k] = 0;
    endtask

    task automatic model_step(input int k, input logic [1:0] rv, input logic [7:0] ad,
                              input logic [27:0] dt, input logic [2:0] cr);
        e_rr[k] = 0; e_rv[k] = 0; e_err[k] = 0;
        if (m_gap[k]) begin
            m_gap[k] = 0;
            e_cv[k]  = 0;
        end else if (m_owner[k] >= 0) begin
            if (cr == 3'b111 || m_age[k] == m_to[k] - 1) begin
                e_rv[k]  = 2'(1 << m_owner[k]);
                e_err[k] = (cr != 3'b111);
                if (e_err[k] && e_cnt[k] < 255) e_cnt[k]++;
                m_owner[k] = -1;
                m_gap[k]   = 1;
                e_cv[k]    = 0;
            end else begin
                m_age[k]++;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                int i;
                i = (m_rr[k] + j) % 2;
                if (m_owner[k] < 0 && rv[i]) begin
                    m_owner[k] = i;
                    e_cv[k]    = 1;
                    e_rr[k]    = 2'(1 << i);
                    e_addr[k]  = ad[i*4 +: 4];
                    e_data[k]  = dt[i*14 +: 14];
                    m_age[k]   = 0;
                    m_rr[k]    = (i + 1) % 2;
                end
            end
        end
        e_busy[k] = (m_owner[k] >= 0) || m_gap[k];
    endtask

    task automatic chk(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", name, k, got, want, $time);
        end
    endtask

    // Advance model on each edge; an asserted reset clears it asynchronously.
    always @(posedge clk) begin
        if (rst_n) begin
            model_step(0, bi0.req_valid, bi0.req_addr, bi0.req_data, bi0.c_ready);
            model_step(1, bi1.req_valid, bi1.req_addr, bi1.req_data, bi1.c_ready);
        end
    end
    always @(negedge rst_n) begin
        model_reset(0);
        model_reset(1);
    end

    // Compare every output of both arbiters against the model mid-cycle.
    always @(negedge clk) begin
        chk("req_ready", 0, 32'(bi0.req_ready), 32'(e_rr[0]));
        chk("rsp_valid", 0, 32'(bi0.rsp_valid), 32'(e_rv[0]));
        chk("rsp_err",   0, 32'(bi0.rsp_err),   32'(e_err[0]));
        chk("c_valid",   0, 32'(bi0.c_valid),   32'(e_cv[0]));
        chk("c_addr",    0, 32'(bi0.c_addr),    32'(e_addr[0]));
        chk("c_data",    0, 32'(bi0.c_data),    32'(e_data[0]));
        chk("busy",      0, 32'(busy0),         32'(e_busy[0]));
        chk("err_cnt",   0, 32'(err0),          32'(e_cnt[0]));
        chk("req_ready", 1, 32'(bi1.req_ready), 32'(e_rr[1]));
        chk("rsp_valid", 1, 32'(bi1.rsp_valid), 32'(e_rv[1]));
        chk("rsp_err",   1, 32'(bi1.rsp_err),   32'(e_err[1]));
        chk("c_valid",   1, 32'(bi1.c_valid),   32'(e_cv[1]));
        chk("c_addr",    1, 32'(bi1.c_addr),    32'(e_addr[1]));
        chk("c_data",    1, 32'(bi1.c_data),    32'(e_data[1]));
        chk("busy",      1, 32'(busy1),         32'(e_busy[1]));
        chk("err_cnt",   1, 32'(err1),          32'(e_cnt[1]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants[$];
        int gcyc[$];
        int cyc;
        int n;
        int cv;
        int rsp;
        int bcnt;

        model_reset(0);
        model_reset(1);
        bi0.req_valid = 0; bi0.req_addr = 0; bi0.req_data = 0; bi0.c_ready = 3'b111;
        bi1.req_valid = 0; bi1.req_addr = 0; bi1.req_data = 0; bi1.c_ready = 3'b111;

        // Reset state
        tick();
        chk("rst_c_valid", 0, 32'(bi0.c_valid), 0);
        chk("rst_busy",    0, 32'(busy0), 0);
        chk("rst_err_cnt", 1, 32'(err1), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Test 1: single write, all slaves ready
        bi0.req_addr  = 8'h02;
        bi0.req_data  = {14'h0, 14'h0A5};
        bi0.req_valid = 2'b01;
        tick();
        chk("t1_req_ready", 0, 32'(bi0.req_ready), 32'h1);
        chk("t1_c_valid",   0, 32'(bi0.c_valid), 32'h1);
        chk("t1_c_addr",    0, 32'(bi0.c_addr), 32'h2);
        chk("t1_c_data",    0, 32'(bi0.c_data), 32'h0A5);
        bi0.req_valid = 2'b00;
        bcnt = busy0 ? 1 : 0;
        tick();
        chk("t1_rsp_valid", 0, 32'(bi0.rsp_valid), 32'h1);
        chk("t1_rsp_err",   0, 32'(bi0.rsp_err), 32'h0);
        bcnt += busy0 ? 1 : 0;
        tick();
        bcnt += busy0 ? 1 : 0;
        chk("t1_busy_cycles", 0, 32'(bcnt), 32'd2);
        $display("txn t1: req0 addr=2 data=0A5 done, busy cycles=%0d", bcnt);

        // Test 2: both requesters held, round-robin alternation
        do_reset();
        bi0.req_addr  = 8'h73;
        bi0.req_data  = {14'h0111, 14'h0222};
        bi0.req_valid = 2'b11;
        cyc = 0;
        while (grants.size() < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (bi0.req_ready != 0) begin
                grants.push_back(bi0.req_ready[1] ? 1 : 0);
                gcyc.push_back(cyc);
                $display("txn t2: grant req%0d at cycle %0d", grants[$], cyc);
            end
        end
        bi0.req_valid = 2'b00;
        chk("t2_grant_count", 0, 32'(grants.size()), 32'd4);
        if (grants.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_grant_order", 0, 32'(grants[i]), 32'(i % 2));
                if (i > 0) chk("t2_grant_spacing", 0, 32'(gcyc[i] - gcyc[i-1]), 32'd3);
            end
        end
        repeat (4) tick();

        // Test 3: slaves stall 10 cycles; bus payload must hold
        do_reset();
        bi0.c_ready   = 3'b011;
        bi0.req_addr  = 8'h50;
        bi0.req_data  = {14'h1234, 14'h0000};
        bi0.req_valid = 2'b10;
        tick();
        chk("t3_req_ready", 0, 32'(bi0.req_ready), 32'h2);
        bi0.req_valid = 2'b00;
        for (int i = 0; i < 10; i++) begin
            chk("t3_c_valid", 0, 32'(bi0.c_valid), 32'h1);
            chk("t3_c_addr",  0, 32'(bi0.c_addr), 32'h5);
            chk("t3_c_data",  0, 32'(bi0.c_data), 32'h1234);
            tick();
        end
        bi0.c_ready = 3'b111;
        tick();
        chk("t3_rsp_valid", 0, 32'(bi0.rsp_valid), 32'h2);
        chk("t3_rsp_err",   0, 32'(bi0.rsp_err), 32'h0);
        chk("t3_err_cnt",   0, 32'(err0), 32'h0);
        $display("txn t3: req1 stalled write done err=%0d", bi0.rsp_err);
        tick();

        // Test 5 (TIMEOUT=8): all-ready arrives on the last drive edge
        bi1.c_ready   = 3'b101;
        bi1.req_addr  = 8'h0C;
        bi1.req_data  = {14'h0, 14'h3FFF};
        bi1.req_valid = 2'b01;
        tick();
        bi1.req_valid = 2'b00;
        repeat (7) tick();
        chk("t5_c_valid", 1, 32'(bi1.c_valid), 32'h1);
        bi1.c_ready = 3'b111;
        tick();
        chk("t5_rsp_valid", 1, 32'(bi1.rsp_valid), 32'h1);
        chk("t5_rsp_err",   1, 32'(bi1.rsp_err), 32'h0);
        chk("t5_err_cnt",   1, 32'(err1), 32'h0);
        $display("txn t5: late all-ready err=%0d err_cnt=%0d", bi1.rsp_err, err1);
        tick();

        // Test 4 (TIMEOUT=8): stuck slave times out, then saturate counter
        bi1.c_ready   = 3'b101;
        bi1.req_valid = 2'b01;
        tick();
        bi1.req_valid = 2'b00;
        cv = 0;
        n  = 0;
        while (bi1.rsp_valid == 0 && n < 30) begin
            if (bi1.c_valid) cv++;
            tick();
            n++;
        end
        chk("t4_c_valid_cycles", 1, 32'(cv), 32'd8);
        chk("t4_rsp_valid", 1, 32'(bi1.rsp_valid), 32'h1);
        chk("t4_rsp_err",   1, 32'(bi1.rsp_err), 32'h1);
        chk("t4_err_cnt",   1, 32'(err1), 32'd1);
        $display("txn t4: timeout after %0d valid cycles err_cnt=%0d", cv, err1);
        tick();
        rsp = 1;
        n   = 0;
        bi1.req_valid = 2'b01;
        while (rsp < 300 && n < 5000) begin
            tick();
            n++;
            if (bi1.rsp_valid != 0) rsp++;
        end
        bi1.req_valid = 2'b00;
        chk("t4_rsp_count", 1, 32'(rsp), 32'd300);
        chk("t4_err_sat",   1, 32'(err1), 32'd255);
        $display("txn t4: %0d timeouts err_cnt=%0d", rsp, err1);
        repeat (2) tick();

        // Test 6: reset during drive, then req1 wins first
        do_reset();
        bi0.c_ready   = 3'b000;
        bi0.req_valid = 2'b01;
        tick();
        bi0.req_valid = 2'b00;
        repeat (3) tick();
        chk("t6_c_valid_pre", 0, 32'(bi0.c_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_c_valid_rst",   0, 32'(bi0.c_valid), 32'h0);
        chk("t6_busy_rst",      0, 32'(busy0), 32'h0);
        chk("t6_rsp_valid_rst", 0, 32'(bi0.rsp_valid), 32'h0);
        bi0.req_valid = 2'b10;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_req_ready", 0, 32'(bi0.req_ready), 32'h2);
        $display("txn t6: after reset grant=%0b", bi0.req_ready);
        bi0.req_valid = 2'b00;
        bi0.c_ready   = 3'b111;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
